// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the turn-sequencing controller
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TURN,
        COMMIT,
        CHECK,
        DONE
    } gstate_t;

    localparam int CELL_EMPTY = 0;

    function automatic int unsigned next_player(input int unsigned p, input int unsigned nplayers);
        return (p >= nplayers) ? 32'd1 : p + 32'd1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn cycle counter with restart, enable and expire pulse
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, restart, enable};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] cnt;

            // expire lands on the TIMEOUT_CYCLES-th enabled cycle, then the count self-restarts
            assign expire = enable && (cnt == LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (restart || expire) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/game_controller_n.sv
// rtl/game_controller_n.sv - N-player turn sequencer: clear sweep, move legality, commit, timeout, tie detect
module game_controller_n
    import game_pkg::*;
#(
    parameter int NPLAYERS       = 2,
    parameter int NCELLS         = 9,
    parameter int AW             = 4,
    parameter int PW             = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] first_player,
    input  logic          move_valid,
    input  logic [AW-1:0] move_addr,
    input  logic [PW-1:0] cell_rd_data,
    input  logic          game_done,
    input  logic [PW-1:0] winner,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [PW-1:0] wr_data,
    output logic [PW-1:0] cur_player,
    output logic          busy,
    output logic          move_reject,
    output logic          turn_timeout,
    output logic [AW-1:0] move_count,
    output logic          result_valid,
    output logic [PW-1:0] result_player,
    output logic          result_tie
);

    localparam logic [AW-1:0] NC = AW'(NCELLS);
    localparam logic [PW-1:0] NP = PW'(NPLAYERS);

    gstate_t       state, state_n;
    logic          mv_prev;
    logic          wr_en_n, reject_n, timeout_n, tie_n;
    logic [AW-1:0] wr_addr_n, move_count_n;
    logic [PW-1:0] wr_data_n, cur_n, result_player_n;
    logic [PW-1:0] cur_adv;
    logic          move_edge, move_legal, expire;

    assign move_edge  = move_valid && !mv_prev;
    assign move_legal = (move_addr != '0) && (move_addr <= NC) && (cell_rd_data == PW'(CELL_EMPTY));
    assign cur_adv    = PW'(next_player(32'(cur_player), NPLAYERS));
    assign busy       = (state == CLEAR) || (state == TURN) || (state == COMMIT) || (state == CHECK);

    turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (ph1),
        .rst_n   (reset),
        .restart (state != TURN),
        .enable  (state == TURN),
        .expire  (expire)
    );

    always_comb begin
        state_n         = state;
        wr_en_n         = 1'b0;
        wr_addr_n       = wr_addr;
        wr_data_n       = wr_data;
        cur_n           = cur_player;
        move_count_n    = move_count;
        reject_n        = 1'b0;
        timeout_n       = 1'b0;
        result_player_n = result_player;
        tie_n           = result_tie;

        case (state)
            CLEAR: begin
                if (wr_addr < NC) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr + AW'(1);
                    wr_data_n = '0;
                end else begin
                    state_n = TURN;
                end
            end
            TURN: begin
                if (move_edge && move_legal) begin
                    state_n      = COMMIT;
                    wr_en_n      = 1'b1;
                    wr_addr_n    = move_addr;
                    wr_data_n    = cur_player;
                    move_count_n = move_count + AW'(1);
                end else begin
                    reject_n = move_edge;
                    if (expire) begin
                        timeout_n = 1'b1;
                        cur_n     = cur_adv;
                    end
                end
            end
            COMMIT: state_n = CHECK;
            CHECK: begin
                if (game_done) begin
                    state_n         = DONE;
                    result_player_n = winner;
                end else if (move_count == NC) begin
                    state_n         = DONE;
                    tie_n           = 1'b1;
                    result_player_n = '0;
                end else begin
                    state_n = TURN;
                    cur_n   = cur_adv;
                end
            end
            default: ;
        endcase

        // start outranks everything: the first clear write goes out on the next cycle
        if (start) begin
            state_n         = CLEAR;
            wr_en_n         = 1'b1;
            wr_addr_n       = AW'(1);
            wr_data_n       = '0;
            cur_n           = ((first_player == '0) || (first_player > NP)) ? PW'(1) : first_player;
            move_count_n    = '0;
            reject_n        = 1'b0;
            timeout_n       = 1'b0;
            result_player_n = '0;
            tie_n           = 1'b0;
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mv_prev       <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            cur_player    <= '0;
            move_reject   <= 1'b0;
            turn_timeout  <= 1'b0;
            move_count    <= '0;
            result_valid  <= 1'b0;
            result_player <= '0;
            result_tie    <= 1'b0;
        end else begin
            state         <= state_n;
            mv_prev       <= move_valid;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_addr_n;
            wr_data       <= wr_data_n;
            cur_player    <= cur_n;
            move_reject   <= reject_n;
            turn_timeout  <= timeout_n;
            move_count    <= move_count_n;
            result_valid  <= (state_n == DONE);
            result_player <= result_player_n;
            result_tie    <= tie_n;
        end
    end

endmodule

// File: tb/tb_game_controller_n.sv
// tb/tb_game_controller_n.sv - self-checking bench for game_controller_n (3 players, 9 cells, timeout 8)
module tb_game_controller_n;

    localparam int NP = 3;
    localparam int NC = 9;
    localparam int TO = 8;

    logic       ph1 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] first_player = '0;
    logic       move_valid = 1'b0;
    logic [3:0] move_addr = '0;
    logic [2:0] cell_rd_data;
    logic       game_done = 1'b0;
    logic [2:0] winner = '0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] cur_player;
    logic       busy;
    logic       move_reject;
    logic       turn_timeout;
    logic [3:0] move_count;
    logic       result_valid;
    logic [2:0] result_player;
    logic       result_tie;

    logic [2:0] mem [0:15];
    int n_cmp = 0;
    int n_err = 0;

    int board [0:15];
    int cur, count, age;
    bit mv_last, in_game;

    game_controller_n #(
        .NPLAYERS(NP), .NCELLS(NC), .AW(4), .PW(3), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ph1(ph1), .reset(reset), .start(start), .first_player(first_player),
        .move_valid(move_valid), .move_addr(move_addr), .cell_rd_data(cell_rd_data),
        .game_done(game_done), .winner(winner),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_player(cur_player),
        .busy(busy), .move_reject(move_reject), .turn_timeout(turn_timeout),
        .move_count(move_count), .result_valid(result_valid),
        .result_player(result_player), .result_tie(result_tie)
    );

    always #5 ph1 = ~ph1;

    assign cell_rd_data = mem[move_addr];
    always @(posedge ph1) if (wr_en) mem[wr_addr] <= wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    function automatic int nxt(input int p);
        return (p >= NP) ? 1 : p + 1;
    endfunction

    function automatic bit is_legal(input int a);
        return (a >= 1) && (a <= NC) && (board[a] == 0);
    endfunction

    function automatic int pick_free();
        int s;
        s = $urandom_range(1, NC);
        for (int i = 0; i < NC; i++) begin
            int c;
            c = ((s - 1 + i) % NC) + 1;
            if (board[c] == 0) return c;
        end
        return 0;
    endfunction

    task automatic start_game(input int fp);
        start = 1'b1;
        first_player = fp[2:0];
        move_valid = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k <= NC; k++) begin
            chk("clr_wr_en", wr_en, 1);
            chk("clr_addr", wr_addr, k);
            chk("clr_data", wr_data, 0);
            chk("clr_busy", busy, 1);
            chk("clr_count", move_count, 0);
            step();
        end
        for (int i = 0; i < 16; i++) board[i] = 0;
        cur = (fp == 0 || fp > NP) ? 1 : fp;
        count = 0;
        age = 0;
        mv_last = 1'b0;
        in_game = 1'b1;
        chk("turn_wr_en", wr_en, 0);
        chk("turn_cur", cur_player, cur);
        chk("turn_result_valid", result_valid, 0);
    endtask

    // one cycle spent in TURN with the given move_valid level and address
    task automatic turn_step(input bit mv, input int a);
        bit edge_seen, legal, rej, to;
        move_valid = mv;
        move_addr = a[3:0];
        edge_seen = mv && !mv_last;
        legal = edge_seen && is_legal(a);
        rej = edge_seen && !legal;
        to = !legal && (age == TO - 1);
        step();
        mv_last = mv;
        chk("move_reject", move_reject, rej);
        chk("turn_timeout", turn_timeout, to);
        chk("wr_en", wr_en, legal);
        if (legal) begin
            chk("wr_addr", wr_addr, a);
            chk("wr_data", wr_data, cur);
            chk("move_count", move_count, count + 1);
            count++;
            board[a] = cur;
            step();
            chk("commit_one_cycle", wr_en, 0);
            chk("check_busy", busy, 1);
            chk("board_written", mem[a], board[a]);
            step();
            if (game_done) begin
                chk("win_valid", result_valid, 1);
                chk("win_player", result_player, winner);
                chk("win_tie", result_tie, 0);
                chk("win_busy", busy, 0);
                in_game = 1'b0;
            end else if (count == NC) begin
                chk("tie_valid", result_valid, 1);
                chk("tie_flag", result_tie, 1);
                chk("tie_player", result_player, 0);
                chk("tie_busy", busy, 0);
                in_game = 1'b0;
            end else begin
                cur = nxt(cur);
                age = 0;
                chk("next_cur", cur_player, cur);
                chk("next_busy", busy, 1);
            end
        end else if (to) begin
            cur = nxt(cur);
            age = 0;
            chk("timeout_cur", cur_player, cur);
        end else begin
            age++;
            chk("hold_cur", cur_player, cur);
        end
    endtask

    initial begin
        int a, r, iter;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cur", cur_player, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", move_count, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_reject", move_reject, 0);
        chk("rst_timeout", turn_timeout, 0);
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        start_game(2);
        turn_step(1, 5);
        turn_step(0, 5);
        turn_step(1, 5);
        turn_step(0, 5);
        turn_step(1, 0);
        turn_step(0, 0);
        turn_step(1, 1);
        repeat (10) turn_step(1, 1);
        turn_step(0, 1);
        repeat (10) turn_step(0, 0);
        while (age != TO - 1) turn_step(0, 0);
        a = pick_free();
        turn_step(1, a);
        turn_step(0, a);

        iter = 0;
        while (in_game && iter < 300) begin
            iter++;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                a = pick_free();
                turn_step(1, a);
                if (in_game) turn_step(0, a);
            end else if (r < 8) begin
                a = $urandom_range(0, 15);
                turn_step(1, a);
                if (in_game) turn_step(0, a);
            end else begin
                repeat ($urandom_range(1, 4)) turn_step(0, 0);
            end
        end
        chk("tie_reached", in_game, 0);
        repeat (3) step();
        chk("done_hold_valid", result_valid, 1);
        chk("done_hold_tie", result_tie, 1);

        start_game(0);
        for (int m = 1; m <= 3; m++) begin
            turn_step(1, m);
            turn_step(0, m);
        end
        game_done = 1'b1;
        winner = 3'd3;
        turn_step(1, 4);
        chk("win_reached", in_game, 0);
        repeat (3) step();
        chk("win_hold_player", result_player, 3);
        chk("win_hold_valid", result_valid, 1);
        game_done = 1'b0;
        winner = '0;

        start_game(3);
        turn_step(1, 7);
        turn_step(0, 7);
        chk("abort_pre_count", move_count, 1);
        start_game(1);

        move_valid = 1'b1;
        move_addr = 4'd2;
        step();
        chk("commit_wr_en", wr_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cur", cur_player, 0);
        chk("async_rst_count", move_count, 0);
        step();
        move_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_wr_en", wr_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_controller_n.md
# game_controller_n

Parametrised turn-sequencing controller for the tic-tac-toe game, generalised to NPLAYERS players on an NCELLS board. It edge-detects player move requests and rejects illegal moves (out-of-range or occupied cell). It writes legal moves into the board memory, enforces a per-turn timeout, detects a full-board tie and clears the board before each game. It sits between the player input block and the board memory/win-checker, replacing the fixed two-player controller.

## Interface
- NPLAYERS, 2: number of players, 2..7; player IDs are 1..NPLAYERS.
- NCELLS, 9: playable cells, addressed 1..NCELLS; address 0 is the null address and never written.
- AW, 4: address width; must satisfy 2^AW > NCELLS.
- PW, 3: player/cell-code width; must satisfy 2^PW > NPLAYERS. Cell code 0 = empty.
- TIMEOUT_CYCLES, 1024: cycles allowed per turn; 0 disables the timeout.

Ports:
- ph1  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new game (clear, then play).
- first_player  in  PW  player who moves first, sampled on start; 0 or >NPLAYERS is treated as 1.
- move_valid  in  1  level from the player input; its rising edge is a move request.
- move_addr  in  AW  requested cell.
- cell_rd_data  in  PW  combinational board read of move_addr.
- game_done  in  1  win-checker flag.
- winner  in  PW  win-checker winner ID, 0 = none.
- wr_en  out  1  board write strobe.
- wr_addr  out  AW  board write address.
- wr_data  out  PW  board write data.
- cur_player  out  PW  player to move.
- busy  out  1  high in CLEAR, TURN, COMMIT, CHECK.
- move_reject  out  1  one-cycle pulse on an illegal move request.
- turn_timeout  out  1  one-cycle pulse when a turn is forfeited.
- move_count  out  AW  legal moves committed this game.
- result_valid  out  1  high in DONE.
- result_player  out  PW  winner ID, 0 for tie.
- result_tie  out  1  board full with no winner.

## Operation
- States (gstate_t): IDLE, CLEAR, TURN, COMMIT, CHECK, DONE.
- Reset values: state IDLE; all outputs 0; internal move_valid history 0.
- IDLE: wait for start, then go to CLEAR. Load cur_player from first_player. Zero move_count and results.
- CLEAR: write 0 to addresses 1..NCELLS, one per cycle (NCELLS cycles, ascending), then go to TURN.
- TURN: the turn timer counts. On a move_valid rising edge:
  - Illegal request (move_addr==0, move_addr>NCELLS, or cell_rd_data!=0): pulse move_reject, stay in TURN. The timer does not restart.
  - Legal request: register wr_en=1, wr_addr=move_addr, wr_data=cur_player; increment move_count; go to COMMIT.
- COMMIT: wr_en is high for exactly this one cycle. Then go to CHECK.
- CHECK: sample game_done/winner, which reflect the committed move.
  - game_done=1: go to DONE with result_player=winner.
  - Else if move_count==NCELLS: go to DONE with result_tie=1, result_player=0.
  - Else: advance cur_player (NPLAYERS wraps to 1), restart the timer, return to TURN.
- Timeout: when the timer reaches TIMEOUT_CYCLES in TURN, pulse turn_timeout, advance cur_player, restart the timer. No write occurs.
- DONE: hold all results. start goes to CLEAR for a new game.
- start during CLEAR/TURN/COMMIT/CHECK aborts the game and goes to CLEAR. Any pending write is dropped if not yet in COMMIT.
- A level held high on move_valid produces one request only. A further request needs low then high again.

## Timing
- Move request edge seen at cycle t gives wr_en high at t+1. CHECK is at t+2, and TURN or DONE is reached at t+3.
- move_reject is asserted at t+1 relative to the edge.
- Rising edges of move_valid outside TURN are ignored. The edge history updates in every state.
- Same cycle as the timeout: a legal move edge has priority over the timeout, and the timeout is suppressed. start has priority over both.
- Reset asserted mid-game forces IDLE immediately and drops wr_en asynchronously.

## Structure
- game_pkg holds: gstate_t enum, CELL_EMPTY = 0, and the player-advance wrap function.
- Sub-module turn_timer: counter with restart, enable and expire pulse, parametrised by TIMEOUT_CYCLES. It is constant-disabled when TIMEOUT_CYCLES is 0.

## Test plan
- Reset low then high; start with first_player=2, NPLAYERS=3 → 9 clear writes (addresses 1..9, data 0), then TURN with cur_player=2.
- Legal move at addr 5 with cell_rd_data=0 → one wr_en (addr 5, data 2), move_count=1, cur_player=3. The next legal move wraps cur_player to 1.
- move_addr=5 with cell_rd_data=2, and move_addr=0 → move_reject pulse each time, no wr_en, cur_player unchanged. move_valid held high 10 cycles → one request only.
- TIMEOUT_CYCLES=8, no input → turn_timeout at cycle 8 of TURN and cur_player advances. Edge and expiry in the same cycle → the move commits with no timeout pulse.
- Nine legal moves with game_done=0 → DONE, result_tie=1, result_player=0. Separate run with game_done=1 and winner=3 in CHECK after move 4 → DONE, result_player=3.
- start mid-TURN → CLEAR sweep and move_count=0. reset asserted during COMMIT → wr_en drops immediately and state is IDLE.
